ifm_rf_seq_ctrl: RTL and testbench

Sequencer for the 16-lane double-banked, skewed IFM shift register-file bank. It splits a job of num_windows output windows into groups of BUFFER_COUNT windows. Each group is loaded into one bank while the other bank drains into the systolic array. The block issues IFM buffer reads and drives demux/mux, the per-bank shift enables and the lane-count "size" mask, with array-side valid flags.

---
 rtl/ifm_rf_seq_ctrl_pkg.sv | 22 ++
 rtl/ifm_rf_phase_cnt.sv | 36 +++
 rtl/ifm_rf_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ifm_rf_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_rf_seq_ctrl_pkg.sv
// rtl/ifm_rf_seq_ctrl_pkg.sv - shared state encoding and geometry helpers for the IFM RF sequencer
package ifm_rf_seq_ctrl_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_FILL  = 3'd1;
    localparam seq_state_t ST_RUN   = 3'd2;
    localparam seq_state_t ST_DRAIN = 3'd3;
    localparam seq_state_t ST_DONE  = 3'd4;

    // Deepest lane of the skewed bank: last lane is delayed by BUFFER_COUNT-1 slots.
    function automatic int lane_depth(input int buffer_size, input int buffer_count);
        return buffer_size + buffer_count - 1;
    endfunction

    // One load/drain phase also has to absorb the IFM buffer read latency.
    function automatic int phase_len(input int buffer_size, input int buffer_count, input int rd_latency);
        return lane_depth(buffer_size, buffer_count) + rd_latency;
    endfunction

endpackage

// File: rtl/ifm_rf_phase_cnt.sv
// rtl/ifm_rf_phase_cnt.sv - phase cycle counter with wrap pulse and write-group counter
module ifm_rf_phase_cnt #(
    parameter int P_LEN = 43,
    parameter int CW    = 6,
    parameter int GW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] c,
    output logic [GW-1:0] w,
    output logic          wrap
);

    localparam logic [CW-1:0] C_LAST = CW'(P_LEN - 1);

    assign wrap = en && (c == C_LAST);

    // Cycle-in-phase counter; group index advances once per completed phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            w <= '0;
        end else if (clear) begin
            c <= '0;
            w <= '0;
        end else if (wrap) begin
            c <= '0;
            w <= w + GW'(1);
        end else if (en) begin
            c <= c + CW'(1);
        end
    end

endmodule

// File: rtl/ifm_rf_seq_ctrl.sv
// rtl/ifm_rf_seq_ctrl.sv - double-banked skewed IFM RF sequencer (load one bank, drain the other)
module ifm_rf_seq_ctrl
    import ifm_rf_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_SIZE  = 27,
    parameter int BUFFER_COUNT = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int RD_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           num_windows,
    output logic                  busy,
    output logic                  done,
    output logic                  ifm_rd_en,
    output logic [ADDR_WIDTH-1:0] ifm_rd_addr,
    output logic                  ifm_pad,
    output logic                  ifm_demux,
    output logic                  ifm_mux,
    output logic                  ifm_RF_shift_en_1,
    output logic                  ifm_RF_shift_en_2,
    output logic [4:0]            size,
    output logic                  arr_valid,
    output logic                  arr_last
);

    localparam int L  = lane_depth(BUFFER_SIZE, BUFFER_COUNT);
    localparam int P  = phase_len(BUFFER_SIZE, BUFFER_COUNT, RD_LATENCY);
    localparam int CW = $clog2(P);
    localparam int GW = 16;

    localparam logic [CW-1:0] C_RD_END    = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] C_SHIFT_BEG = CW'(RD_LATENCY);
    localparam logic [CW-1:0] C_PAD_BEG   = CW'(RD_LATENCY + BUFFER_SIZE);
    localparam logic [CW-1:0] C_DRAIN_END = CW'(L);
    localparam logic [CW-1:0] C_ARR_LAST  = CW'(L - 1);
    localparam logic [4:0]    SIZE_FULL   = 5'(BUFFER_COUNT);

    // Element width belongs to the RF bank datapath; the sequencer only guards it.
    if (DATA_WIDTH < 1 || RD_LATENCY < 1) begin : g_param_guard
    end

    seq_state_t     state;
    logic [15:0]    num_q;
    logic [16:0]    grp_q;
    logic [16:0]    grp_n;
    logic [CW-1:0]  c;
    logic [GW-1:0]  w;
    logic           wrap;
    logic           cnt_en;
    logic           accept;

    assign accept = start && (state == ST_IDLE) && !busy;
    assign cnt_en = (state == ST_FILL) || (state == ST_RUN) || (state == ST_DRAIN);
    assign grp_n  = 17'((32'(num_windows) + 32'(BUFFER_COUNT - 1)) / 32'(BUFFER_COUNT));

    ifm_rf_phase_cnt #(
        .P_LEN (P),
        .CW    (CW),
        .GW    (GW)
    ) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (cnt_en),
        .c     (c),
        .w     (w),
        .wrap  (wrap)
    );

    // Job FSM: FILL loads group 0, each RUN loads one group while draining the previous, DRAIN empties the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            num_q <= '0;
            grp_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        num_q <= num_windows;
                        grp_q <= grp_n;
                        state <= (num_windows == 16'd0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wrap) begin
                        state <= (grp_q > 17'd1) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_RUN: begin
                    if (wrap && ({1'b0, w} == grp_q - 17'd1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wrap) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic                  write_act;
    logic                  read_act;
    logic                  wr_bank;
    logic                  rd_bank;
    logic                  wr_shift;
    logic                  rd_shift;
    logic [31:0]           remaining;
    logic                  n_rd_en;
    logic [ADDR_WIDTH-1:0] n_addr;
    logic [4:0]            n_size;

    // Decode of the current phase position into next-cycle output values.
    always_comb begin
        write_act = (state == ST_FILL) || (state == ST_RUN);
        read_act  = (state == ST_RUN) || (state == ST_DRAIN);
        wr_bank   = w[0];
        rd_bank   = ~w[0];
        wr_shift  = write_act && (c >= C_SHIFT_BEG);
        rd_shift  = read_act && (c < C_DRAIN_END);
        remaining = 32'(num_q) - 32'(w) * 32'(BUFFER_COUNT);
        n_rd_en   = write_act && (c < C_RD_END);
        n_addr    = '0;
        if (n_rd_en) begin
            n_addr = ADDR_WIDTH'(w) * ADDR_WIDTH'(BUFFER_SIZE) + ADDR_WIDTH'(c);
        end
        n_size = SIZE_FULL;
        if (write_act && (remaining < 32'(BUFFER_COUNT))) begin
            n_size = remaining[4:0];
        end
    end

    // Registered outputs; reset parks everything idle with a full lane mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_rd_en         <= 1'b0;
            ifm_rd_addr       <= '0;
            ifm_pad           <= 1'b0;
            ifm_demux         <= 1'b0;
            ifm_mux           <= 1'b0;
            ifm_RF_shift_en_1 <= 1'b0;
            ifm_RF_shift_en_2 <= 1'b0;
            size              <= SIZE_FULL;
            arr_valid         <= 1'b0;
            arr_last          <= 1'b0;
            done              <= 1'b0;
        end else begin
            ifm_rd_en         <= n_rd_en;
            ifm_rd_addr       <= n_addr;
            ifm_pad           <= write_act && (c >= C_PAD_BEG);
            ifm_demux         <= write_act && wr_bank;
            ifm_mux           <= read_act && rd_bank;
            ifm_RF_shift_en_1 <= (wr_shift && !wr_bank) || (rd_shift && !rd_bank);
            ifm_RF_shift_en_2 <= (wr_shift && wr_bank) || (rd_shift && rd_bank);
            size              <= n_size;
            arr_valid         <= rd_shift;
            arr_last          <= (state == ST_DRAIN) && (c == C_ARR_LAST);
            done              <= (state == ST_DONE);
        end
    end

    // Busy covers the whole job including the visible done cycle, so a start there is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifm_rf_seq_ctrl.sv
// tb/tb_ifm_rf_seq_ctrl.sv - self-checking bench for ifm_rf_seq_ctrl
module tb_ifm_rf_seq_ctrl;

    localparam int BS  = 27;
    localparam int BC  = 16;
    localparam int LAT = 1;
    localparam int L   = BS + BC - 1;
    localparam int P   = L + LAT;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] num_windows;
    logic        busy, done, ifm_rd_en, ifm_pad, ifm_demux, ifm_mux;
    logic        ifm_RF_shift_en_1, ifm_RF_shift_en_2, arr_valid, arr_last;
    logic [15:0] ifm_rd_addr;
    logic [4:0]  size;

    int compared;
    int mismatched;

    ifm_rf_seq_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .num_windows       (num_windows),
        .busy              (busy),
        .done              (done),
        .ifm_rd_en         (ifm_rd_en),
        .ifm_rd_addr       (ifm_rd_addr),
        .ifm_pad           (ifm_pad),
        .ifm_demux         (ifm_demux),
        .ifm_mux           (ifm_mux),
        .ifm_RF_shift_en_1 (ifm_RF_shift_en_1),
        .ifm_RF_shift_en_2 (ifm_RF_shift_en_2),
        .size              (size),
        .arr_valid         (arr_valid),
        .arr_last          (arr_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [15:0] addr;
        logic        pad;
        logic        demux;
        logic        mux;
        logic        se1;
        logic        se2;
        logic [4:0]  size;
        logic        valid;
        logic        last;
    } out_t;

    typedef struct {
        int num;
        int extra_k;
        int exp_done_k;
        int exp_reads;
        int exp_se1;
        int exp_se2;
        int exp_valid;
        int exp_both;
        int exp_last_addr;
        int exp_last_size;
    } vec_t;

    function automatic out_t sample();
        out_t o;
        o.busy  = busy;
        o.done  = done;
        o.rd_en = ifm_rd_en;
        o.addr  = ifm_rd_addr;
        o.pad   = ifm_pad;
        o.demux = ifm_demux;
        o.mux   = ifm_mux;
        o.se1   = ifm_RF_shift_en_1;
        o.se2   = ifm_RF_shift_en_2;
        o.size  = size;
        o.valid = arr_valid;
        o.last  = arr_last;
        return o;
    endfunction

    function automatic out_t idle_out(input logic b);
        out_t e;
        e      = '0;
        e.size = 5'd16;
        e.busy = b;
        return e;
    endfunction

    // Reference: output k cycles after the start-accept edge, from the phase schedule.
    function automatic out_t exp_at(input int num, input int k);
        out_t e;
        int g, dk, j, ph, c, rem;
        g  = (num + BC - 1) / BC;
        dk = (num == 0) ? 1 : (g + 1) * P + 1;
        e  = idle_out(1'(k <= dk));
        e.done = 1'(k == dk);
        if (num > 0 && k >= 1 && k <= (g + 1) * P) begin
            j  = k - 1;
            ph = j / P;
            c  = j % P;
            if (ph < g) begin
                if (c < BS) begin
                    e.rd_en = 1'b1;
                    e.addr  = 16'((ph * BS + c) % 65536);
                end
                e.pad   = 1'(c >= LAT + BS);
                e.demux = 1'(ph % 2);
                rem     = num - BC * ph;
                e.size  = 5'((rem > BC) ? BC : rem);
                if (c >= LAT) begin
                    if (ph % 2 == 0) e.se1 = 1'b1;
                    else             e.se2 = 1'b1;
                end
            end
            if (ph >= 1) begin
                e.mux = 1'((ph - 1) % 2);
                if (c < L) begin
                    e.valid = 1'b1;
                    if ((ph - 1) % 2 == 0) e.se1 = 1'b1;
                    else                   e.se2 = 1'b1;
                    e.last = 1'(ph == g && c == L - 1);
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Starts a job at the current negedge and follows it to idle, checking every cycle.
    task automatic run_job(input string tag, input int num, input int extra_k, input bit rnd_start,
                           output int done_k, output int reads, output int se1, output int se2,
                           output int valid, output int both, output int last_addr, output int last_size);
        int g, dk, bad, first_k;
        out_t o, e, first_o, first_e;
        g  = (num + BC - 1) / BC;
        dk = (num == 0) ? 1 : (g + 1) * P + 1;
        done_k = -1; reads = 0; se1 = 0; se2 = 0; valid = 0; both = 0;
        last_addr = -1; last_size = -1; bad = 0; first_k = -1;
        first_o = '0; first_e = '0;
        num_windows = 16'(num);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= dk + 3; k++) begin
            @(negedge clk);
            o = sample();
            e = exp_at(num, k);
            if (o !== e) begin
                if (bad == 0) begin
                    first_k = k; first_o = o; first_e = e;
                end
                bad++;
            end
            if (o.done && done_k < 0) done_k = k;
            if (o.rd_en) begin
                reads++;
                last_addr = int'(o.addr);
                last_size = int'(o.size);
            end
            if (o.se1) se1++;
            if (o.se2) se2++;
            if (o.valid) valid++;
            if (o.se1 && o.se2) both++;
            if (k == extra_k) begin
                start = 1'b1;
            end else if (rnd_start && k < dk) begin
                start = 1'($urandom_range(0, 3) == 0);
                num_windows = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL trace_%s: %0d cycles differ, first at k=%0d got %h expected %h",
                     tag, bad, first_k, first_o, first_e);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int dk, rd, s1, s2, vl, bo, la, ls, n;
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_windows = '0;

        vecs[0] = '{16,  10,  87,   27,   84,   0,    42,   0,    26,   16};
        vecs[1] = '{0,   1,   1,    0,    0,    0,    0,    0,    -1,   -1};
        vecs[2] = '{33,  173, 173,  81,   168,  84,   126,  82,   80,   1};
        vecs[3] = '{17,  5,   130,  54,   84,   84,   84,   41,   53,   1};
        vecs[4] = '{900, -1,  2495, 1539, 2436, 2352, 2394, 2296, 1538, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", longint'(sample()), longint'(idle_out(1'b0)));
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a RUN phase abandons the job.
        num_windows = 16'd40;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("midrun_busy_before_reset", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrun_async_reset", longint'(sample()), longint'(idle_out(1'b0)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrun_reset_hold_%0d", i), longint'(sample()), longint'(idle_out(1'b0)));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_no_done", longint'(done), 0);
        run_job("post_reset", 16, -1, 1'b0, dk, rd, s1, s2, vl, bo, la, ls);
        check("post_reset_done_k", dk, 87);

        // Directed table: geometry counts and completion timing per job size.
        for (int i = 0; i < 5; i++) begin
            string t;
            t = $sformatf("n%0d", vecs[i].num);
            run_job(t, vecs[i].num, vecs[i].extra_k, 1'b0, dk, rd, s1, s2, vl, bo, la, ls);
            check({t, "_done_k"}, dk, vecs[i].exp_done_k);
            check({t, "_reads"}, rd, vecs[i].exp_reads);
            check({t, "_shift1"}, s1, vecs[i].exp_se1);
            check({t, "_shift2"}, s2, vecs[i].exp_se2);
            check({t, "_valid"}, vl, vecs[i].exp_valid);
            check({t, "_both_shift"}, bo, vecs[i].exp_both);
            check({t, "_last_addr"}, la, vecs[i].exp_last_addr);
            check({t, "_last_size"}, ls, vecs[i].exp_last_size);
        end

        // Random job sizes with stray start pulses and num_windows churn while busy.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 70));
            run_job($sformatf("rand%0d_n%0d", r, n), n, -1, 1'b1, dk, rd, s1, s2, vl, bo, la, ls);
            check($sformatf("rand%0d_done_k", r), dk, ((n + BC - 1) / BC + 1) * P + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
